// File: rtl/axi4_addn_pkg.sv
// Shared definitions for the AXI4-Lite N-operand adder: register map, bit positions,
// response codes, the accumulator FSM state type and the accumulator width helper.
package axi4_addn_pkg;

   localparam logic [7:0] OFF_CTRL      = 8'h00;
   localparam logic [7:0] OFF_STATUS    = 8'h04;
   localparam logic [7:0] OFF_RESULT    = 8'h08;
   localparam logic [7:0] OFF_RESULT_HI = 8'h0C;
   localparam logic [7:0] OFF_OP0       = 8'h10;

   localparam int CTRL_START    = 0;
   localparam int CTRL_SIGNED   = 1;
   localparam int CTRL_CLR_DONE = 2;
   localparam int CTRL_IRQ_EN   = 3;

   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;
   localparam int STAT_OVF  = 2;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } addn_state_t;

   // Enough headroom that summing num_ops full-scale 32-bit values never wraps.
   function automatic int acc_width(input int num_ops);
      return 32 + $clog2(num_ops);
   endfunction

endpackage

// File: rtl/axi4_addn_accum.sv
// Sequencer and datapath: adds one operand per cycle into a widened accumulator,
// then raises the sticky DONE flag and the overflow verdict on the final add.
module axi4_addn_accum
   import axi4_addn_pkg::*;
#(
   parameter int NUM_OPS = 4,
   parameter int ACC_W   = acc_width(NUM_OPS)
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_start,
   input  logic                    i_signed,
   input  logic                    i_clr_done,
   input  logic [NUM_OPS-1:0][31:0] i_ops,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_ovf,
   output logic                    o_signed,
   output logic [ACC_W-1:0]        o_acc
);

   localparam int IDX_W = $clog2(NUM_OPS);

   addn_state_t      r_state;
   logic [IDX_W-1:0] r_idx;
   logic [ACC_W-1:0] r_acc;
   logic             r_done;
   logic             r_ovf;
   logic             r_signed;

   logic [31:0]       w_op;
   logic [ACC_W-1:0]  w_op_ext;
   logic [ACC_W-1:0]  w_acc_next;
   logic [ACC_W-33:0] w_upper;
   logic              w_last;
   logic              w_ovf_next;

   assign w_op       = i_ops[r_idx];
   assign w_op_ext   = r_signed ? {{(ACC_W-32){w_op[31]}}, w_op} : {{(ACC_W-32){1'b0}}, w_op};
   assign w_acc_next = r_acc + w_op_ext;
   assign w_last     = (r_idx == IDX_W'(NUM_OPS-1));
   assign w_upper    = w_acc_next[ACC_W-1:32];

   // Signed results fit in 32 bits only when the headroom bits all copy bit 31.
   assign w_ovf_next = r_signed ? (w_upper != {(ACC_W-32){w_acc_next[31]}}) : (w_upper != '0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= ST_IDLE;
         r_idx    <= '0;
         r_acc    <= '0;
         r_done   <= 1'b0;
         r_ovf    <= 1'b0;
         r_signed <= 1'b0;
      end else if (i_start) begin
         r_state  <= ST_RUN;
         r_idx    <= '0;
         r_acc    <= '0;
         r_done   <= 1'b0;
         r_ovf    <= 1'b0;
         r_signed <= i_signed;
      end else if (r_state == ST_RUN) begin
         r_acc <= w_acc_next;
         r_idx <= r_idx + IDX_W'(1);
         if (w_last) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
            r_ovf   <= w_ovf_next;
         end
      end else if (i_clr_done) begin
         r_done <= 1'b0;
      end
   end

   assign o_busy   = (r_state == ST_RUN);
   assign o_done   = r_done;
   assign o_ovf    = r_ovf;
   assign o_signed = r_signed;
   assign o_acc    = r_acc;

endmodule

// File: rtl/axi4_addn_slave.sv
// AXI4-Lite register front end for the N-operand adder.
// Optional build macro AXI4_ADDN_IRQ_EN adds the CTRL.IRQ_EN bit and a level interrupt.
module axi4_addn_slave
   import axi4_addn_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 7,
   parameter int NUM_OPS            = 4
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic                            irq
);

   localparam int ACC_W       = acc_width(NUM_OPS);
   localparam int IDX_CTRL    = int'(OFF_CTRL) >> 2;
   localparam int IDX_STATUS  = int'(OFF_STATUS) >> 2;
   localparam int IDX_RESULT  = int'(OFF_RESULT) >> 2;
   localparam int IDX_RES_HI  = int'(OFF_RESULT_HI) >> 2;
   localparam int IDX_OP0     = int'(OFF_OP0) >> 2;

   if (C_S_AXI_DATA_WIDTH != 32) begin : g_err_data_width
      $error("axi4_addn_slave: C_S_AXI_DATA_WIDTH must be 32");
   end
   if (NUM_OPS < 2 || NUM_OPS > 16) begin : g_err_num_ops
      $error("axi4_addn_slave: NUM_OPS must be within 2..16");
   end
   if ((1 << C_S_AXI_ADDR_WIDTH) < (16 + 4 * NUM_OPS)) begin : g_err_addr_width
      $error("axi4_addn_slave: C_S_AXI_ADDR_WIDTH too small for NUM_OPS");
   end

   logic                     r_awready;
   logic                     r_bvalid;
   logic [1:0]               r_bresp;
   logic                     r_arready;
   logic                     r_rvalid;
   logic [1:0]               r_rresp;
   logic [31:0]              r_rdata;
   logic [NUM_OPS-1:0][31:0] r_op;
   logic                     r_ctrl_signed;

   logic [31:0]      w_aw_idx;
   logic [31:0]      w_ar_idx;
   logic             w_wr_en;
   logic             w_rd_en;
   logic             w_aw_is_ctrl;
   logic             w_aw_is_ro;
   logic             w_aw_is_op;
   logic             w_wr_err;
   logic             w_ctrl_wr;
   logic             w_op_wr;
   logic             w_start;
   logic             w_clr_done;
   logic             w_busy;
   logic             w_done;
   logic             w_ovf;
   logic             w_acc_signed;
   logic [ACC_W-1:0] w_acc;
   logic [31:0]      w_result_hi;
   logic [31:0]      w_ctrl_rd;
   logic [31:0]      w_rd_data;
   logic [1:0]       w_rd_resp;
   logic             w_unused;

   assign w_aw_idx = 32'(S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2]);
   assign w_ar_idx = 32'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);
   assign w_wr_en  = r_awready & S_AXI_AWVALID & S_AXI_WVALID;
   assign w_rd_en  = r_arready & S_AXI_ARVALID;

   assign w_aw_is_ctrl = (w_aw_idx == IDX_CTRL);
   assign w_aw_is_ro   = (w_aw_idx == IDX_STATUS) || (w_aw_idx == IDX_RESULT) || (w_aw_idx == IDX_RES_HI);
   assign w_aw_is_op   = (w_aw_idx >= IDX_OP0) && (w_aw_idx < IDX_OP0 + NUM_OPS);

   // Operands and CTRL are frozen during a run so the sum is never torn mid-sequence.
   assign w_wr_err   = !(w_aw_is_ctrl || w_aw_is_ro || w_aw_is_op) || (w_busy && (w_aw_is_ctrl || w_aw_is_op));
   assign w_ctrl_wr  = w_wr_en & w_aw_is_ctrl & ~w_busy & S_AXI_WSTRB[0];
   assign w_op_wr    = w_wr_en & w_aw_is_op & ~w_busy;
   assign w_start    = w_ctrl_wr & S_AXI_WDATA[CTRL_START];
   assign w_clr_done = w_ctrl_wr & S_AXI_WDATA[CTRL_CLR_DONE];

   axi4_addn_accum #(
      .NUM_OPS (NUM_OPS),
      .ACC_W   (ACC_W)
   ) u_accum (
      .i_clk      (ACLK),
      .i_rst_n    (ARESETN),
      .i_start    (w_start),
      .i_signed   (S_AXI_WDATA[CTRL_SIGNED]),
      .i_clr_done (w_clr_done),
      .i_ops      (r_op),
      .o_busy     (w_busy),
      .o_done     (w_done),
      .o_ovf      (w_ovf),
      .o_signed   (w_acc_signed),
      .o_acc      (w_acc)
   );

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_awready     <= 1'b0;
         r_bvalid      <= 1'b0;
         r_bresp       <= RESP_OKAY;
         r_op          <= '0;
         r_ctrl_signed <= 1'b0;
      end else begin
         r_awready <= S_AXI_AWVALID & S_AXI_WVALID & ~r_bvalid & ~r_awready;
         if (w_wr_en) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
         end else if (S_AXI_BREADY) begin
            r_bvalid <= 1'b0;
         end
         if (w_ctrl_wr) begin
            r_ctrl_signed <= S_AXI_WDATA[CTRL_SIGNED];
         end
         for (int i = 0; i < NUM_OPS; i++) begin
            if (w_op_wr && (w_aw_idx == 32'(IDX_OP0 + i))) begin
               for (int b = 0; b < 4; b++) begin
                  if (S_AXI_WSTRB[b]) begin
                     r_op[i][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                  end
               end
            end
         end
      end
   end

`ifdef AXI4_ADDN_IRQ_EN
   logic r_ctrl_irq_en;
   logic r_irq;

   // The interrupt falls together with DONE rather than lagging it by a cycle.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_ctrl_irq_en <= 1'b0;
         r_irq         <= 1'b0;
      end else begin
         if (w_ctrl_wr) begin
            r_ctrl_irq_en <= S_AXI_WDATA[CTRL_IRQ_EN];
         end
         r_irq <= (w_start || w_clr_done) ? 1'b0 : (w_done & r_ctrl_irq_en);
      end
   end

   assign irq = r_irq;
`else
   assign irq = 1'b0;
`endif

   assign w_result_hi = w_acc_signed ? {{(64-ACC_W){w_acc[ACC_W-1]}}, w_acc[ACC_W-1:32]}
                                     : {{(64-ACC_W){1'b0}}, w_acc[ACC_W-1:32]};

   always_comb begin
      w_ctrl_rd              = '0;
      w_ctrl_rd[CTRL_SIGNED] = r_ctrl_signed;
`ifdef AXI4_ADDN_IRQ_EN
      w_ctrl_rd[CTRL_IRQ_EN] = r_ctrl_irq_en;
`endif
   end

   always_comb begin
      w_rd_data = '0;
      w_rd_resp = RESP_OKAY;
      if (w_ar_idx == IDX_CTRL) begin
         w_rd_data = w_ctrl_rd;
      end else if (w_ar_idx == IDX_STATUS) begin
         w_rd_data[STAT_BUSY] = w_busy;
         w_rd_data[STAT_DONE] = w_done;
         w_rd_data[STAT_OVF]  = w_ovf;
      end else if (w_ar_idx == IDX_RESULT) begin
         w_rd_data = w_acc[31:0];
      end else if (w_ar_idx == IDX_RES_HI) begin
         w_rd_data = w_result_hi;
      end else if ((w_ar_idx >= IDX_OP0) && (w_ar_idx < IDX_OP0 + NUM_OPS)) begin
         for (int i = 0; i < NUM_OPS; i++) begin
            if (w_ar_idx == 32'(IDX_OP0 + i)) begin
               w_rd_data = r_op[i];
            end
         end
      end else begin
         w_rd_resp = RESP_SLVERR;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rresp   <= RESP_OKAY;
         r_rdata   <= '0;
      end else begin
         r_arready <= S_AXI_ARVALID & ~r_rvalid & ~r_arready;
         if (w_rd_en) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_resp;
         end else if (S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   assign S_AXI_AWREADY = r_awready;
   assign S_AXI_WREADY  = r_awready;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = r_bresp;
   assign S_AXI_ARREADY = r_arready;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RRESP   = r_rresp;
   assign S_AXI_RDATA   = r_rdata;

   assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_axi4_addn_slave.sv
// Scoreboard bench for axi4_addn_slave: tasks queue the expected B/R responses,
// a negedge monitor pops and compares them whenever a response handshake is presented.
module tb_axi4_addn_slave;

`ifdef AXI4_ADDN_IRQ_EN
   localparam logic IRQ_BUILD = 1'b1;
`else
   localparam logic IRQ_BUILD = 1'b0;
`endif

   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic [6:0]  S_AXI_AWADDR;
   logic [2:0]  S_AXI_AWPROT;
   logic        S_AXI_AWVALID;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA;
   logic [3:0]  S_AXI_WSTRB;
   logic        S_AXI_WVALID;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY;
   logic [6:0]  S_AXI_ARADDR;
   logic [2:0]  S_AXI_ARPROT;
   logic        S_AXI_ARVALID;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY;
   logic        irq;

   localparam logic [1:0] OK  = 2'b00;
   localparam logic [1:0] ERR = 2'b10;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [1:0]  bRespQ[$];
   string       bNameQ[$];
   logic [31:0] rDataQ[$];
   logic [1:0]  rRespQ[$];
   string       rNameQ[$];

   axi4_addn_slave #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (7),
      .NUM_OPS            (4)
   ) dut (
      .ACLK          (ACLK),
      .ARESETN       (ARESETN),
      .S_AXI_AWADDR  (S_AXI_AWADDR),
      .S_AXI_AWPROT  (S_AXI_AWPROT),
      .S_AXI_AWVALID (S_AXI_AWVALID),
      .S_AXI_AWREADY (S_AXI_AWREADY),
      .S_AXI_WDATA   (S_AXI_WDATA),
      .S_AXI_WSTRB   (S_AXI_WSTRB),
      .S_AXI_WVALID  (S_AXI_WVALID),
      .S_AXI_WREADY  (S_AXI_WREADY),
      .S_AXI_BRESP   (S_AXI_BRESP),
      .S_AXI_BVALID  (S_AXI_BVALID),
      .S_AXI_BREADY  (S_AXI_BREADY),
      .S_AXI_ARADDR  (S_AXI_ARADDR),
      .S_AXI_ARPROT  (S_AXI_ARPROT),
      .S_AXI_ARVALID (S_AXI_ARVALID),
      .S_AXI_ARREADY (S_AXI_ARREADY),
      .S_AXI_RDATA   (S_AXI_RDATA),
      .S_AXI_RRESP   (S_AXI_RRESP),
      .S_AXI_RVALID  (S_AXI_RVALID),
      .S_AXI_RREADY  (S_AXI_RREADY),
      .irq           (irq)
   );

   always #5 ACLK = ~ACLK;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic reportTimeout(input string name);
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s: handshake timeout, got none, expected one within 50 cycles", name);
   endtask

   // Response monitor: compares every B and R beat against the queued expectation.
   always @(negedge ACLK) begin : monitor
      string n;
      if (ARESETN) begin
         if (S_AXI_BVALID && S_AXI_BREADY) begin
            if (bRespQ.size() == 0) begin
               reportTimeout("unexpected B beat");
            end else begin
               n = bNameQ.pop_front();
               checkOutput({n, " bresp"}, 32'(S_AXI_BRESP), 32'(bRespQ.pop_front()));
            end
         end
         if (S_AXI_RVALID && S_AXI_RREADY) begin
            if (rDataQ.size() == 0) begin
               reportTimeout("unexpected R beat");
            end else begin
               n = rNameQ.pop_front();
               checkOutput({n, " rdata"}, S_AXI_RDATA, rDataQ.pop_front());
               checkOutput({n, " rresp"}, 32'(S_AXI_RRESP), 32'(rRespQ.pop_front()));
            end
         end
      end
   end

   task automatic waitAwReady(input string name);
      bit ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge ACLK);
         if (S_AXI_AWREADY) begin
            ok = 1;
            break;
         end
      end
      if (!ok) reportTimeout({name, " awready"});
      @(posedge ACLK);
      #1;
   endtask

   task automatic waitBResp(input string name);
      bit ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge ACLK);
         if (S_AXI_BVALID && S_AXI_BREADY) begin
            ok = 1;
            break;
         end
      end
      if (!ok) reportTimeout({name, " bvalid"});
      @(posedge ACLK);
      #1;
   endtask

   task automatic applyWrite(input logic [6:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] expResp, input string name);
      bRespQ.push_back(expResp);
      bNameQ.push_back(name);
      S_AXI_AWADDR  = addr;
      S_AXI_WDATA   = data;
      S_AXI_WSTRB   = strb;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b1;
      waitAwReady(name);
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      waitBResp(name);
   endtask

   task automatic applyRead(input logic [6:0] addr, input logic [31:0] expData, input logic [1:0] expResp,
                            input string name);
      bit ok = 0;
      rDataQ.push_back(expData);
      rRespQ.push_back(expResp);
      rNameQ.push_back(name);
      S_AXI_ARADDR  = addr;
      S_AXI_ARVALID = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge ACLK);
         if (S_AXI_ARREADY) begin
            ok = 1;
            break;
         end
      end
      if (!ok) reportTimeout({name, " arready"});
      @(posedge ACLK);
      #1;
      S_AXI_ARVALID = 1'b0;
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge ACLK);
         if (S_AXI_RVALID && S_AXI_RREADY) begin
            ok = 1;
            break;
         end
      end
      if (!ok) reportTimeout({name, " rvalid"});
      @(posedge ACLK);
      #1;
   endtask

   task automatic applyStimulus_writeOps(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
      applyWrite(7'h10, a, 4'hF, OK, "wr OP0");
      applyWrite(7'h14, b, 4'hF, OK, "wr OP1");
      applyWrite(7'h18, c, 4'hF, OK, "wr OP2");
      applyWrite(7'h1C, d, 4'hF, OK, "wr OP3");
   endtask

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation still running, expected to finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      ARESETN       = 1'b0;
      S_AXI_AWADDR  = '0;
      S_AXI_AWPROT  = '0;
      S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA   = '0;
      S_AXI_WSTRB   = '0;
      S_AXI_WVALID  = 1'b0;
      S_AXI_BREADY  = 1'b1;
      S_AXI_ARADDR  = '0;
      S_AXI_ARPROT  = '0;
      S_AXI_ARVALID = 1'b0;
      S_AXI_RREADY  = 1'b1;
      repeat (3) @(posedge ACLK);
      #1;
      ARESETN = 1'b1;
      @(posedge ACLK);
      #1;

      // Reset state of every mapped register
      checkOutput("reset irq", 32'(irq), 32'd0);
      checkOutput("reset bvalid", 32'(S_AXI_BVALID), 32'd0);
      for (int i = 0; i < 8; i++) begin
         applyRead(7'(4 * i), 32'h0, OK, $sformatf("reset rd 0x%02h", 4 * i));
      end

      // Unsigned small sum
      applyStimulus_writeOps(32'd1, 32'd2, 32'd3, 32'd4);
      applyWrite(7'h00, 32'h1, 4'hF, OK, "wr START u");
      applyRead(7'h04, 32'h1, OK, "status busy u");
      applyRead(7'h04, 32'h2, OK, "status done u");
      applyRead(7'h08, 32'hA, OK, "result 1+2+3+4");
      applyRead(7'h0C, 32'h0, OK, "result_hi 1+2+3+4");
      applyRead(7'h00, 32'h0, OK, "ctrl start self-clear");

      // Full-scale operands, unsigned overflow then signed
      applyStimulus_writeOps(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      applyWrite(7'h00, 32'h1, 4'hF, OK, "wr START u max");
      applyRead(7'h04, 32'h1, OK, "status busy u max");
      applyRead(7'h04, 32'h6, OK, "status done+ovf u max");
      applyRead(7'h08, 32'hFFFF_FFFC, OK, "result u max");
      applyRead(7'h0C, 32'h3, OK, "result_hi u max");
      applyWrite(7'h00, 32'h3, 4'hF, OK, "wr START s");
      applyRead(7'h04, 32'h1, OK, "status busy s");
      applyRead(7'h04, 32'h2, OK, "status done s");
      applyRead(7'h08, 32'hFFFF_FFFC, OK, "result s -4");
      applyRead(7'h0C, 32'hFFFF_FFFF, OK, "result_hi s -4");
      applyRead(7'h00, 32'h2, OK, "ctrl signed kept");

      // Operand write while busy is refused
      applyWrite(7'h00, 32'h1, 4'hF, OK, "wr START busy test");
      applyWrite(7'h14, 32'h55, 4'hF, ERR, "wr OP1 while busy");
      applyRead(7'h04, 32'h6, OK, "status after busy write");
      applyRead(7'h14, 32'hFFFF_FFFF, OK, "OP1 unchanged");

      // Unmapped and read-only accesses
      applyRead(7'h7C, 32'h0, ERR, "rd unmapped 0x7C");
      applyWrite(7'h7C, 32'h1234, 4'hF, ERR, "wr unmapped 0x7C");
      applyWrite(7'h04, 32'h0, 4'hF, OK, "wr STATUS ro");
      applyRead(7'h04, 32'h6, OK, "status after ro write");
      applyRead(7'h15, 32'hFFFF_FFFF, OK, "rd OP1 low addr bits ignored");

      // CLR_DONE leaves OVF; START+CLR_DONE starts a fresh run
      applyWrite(7'h00, 32'h4, 4'hF, OK, "wr CLR_DONE");
      applyRead(7'h04, 32'h4, OK, "status after clr_done");
      applyWrite(7'h00, 32'h5, 4'hF, OK, "wr START+CLR_DONE");
      applyRead(7'h04, 32'h1, OK, "status busy start+clr");
      applyRead(7'h04, 32'h6, OK, "status done start+clr");

      // Byte strobes
      applyWrite(7'h10, 32'h0, 4'hF, OK, "wr OP0 zero");
      applyWrite(7'h10, 32'hAABB_CCDD, 4'b0010, OK, "wr OP0 strb 0010");
      applyRead(7'h10, 32'h0000_CC00, OK, "OP0 after strobe");

      // BREADY stalled: BVALID must hold and no second write may be accepted
      S_AXI_BREADY = 1'b0;
      bRespQ.push_back(OK);
      bNameQ.push_back("wr OP2 stalled");
      S_AXI_AWADDR  = 7'h18;
      S_AXI_WDATA   = 32'h1234_5678;
      S_AXI_WSTRB   = 4'hF;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b1;
      waitAwReady("wr OP2 stalled");
      S_AXI_AWADDR = 7'h1C;
      S_AXI_WDATA  = 32'h9;
      for (int i = 0; i < 10; i++) begin
         @(negedge ACLK);
         checkOutput($sformatf("stall bvalid cyc%0d", i), 32'(S_AXI_BVALID), 32'd1);
         checkOutput($sformatf("stall awready cyc%0d", i), 32'(S_AXI_AWREADY), 32'd0);
      end
      @(posedge ACLK);
      #1;
      bRespQ.push_back(OK);
      bNameQ.push_back("wr OP3 queued");
      S_AXI_BREADY = 1'b1;
      waitBResp("wr OP2 stalled");
      waitAwReady("wr OP3 queued");
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      waitBResp("wr OP3 queued");
      applyRead(7'h18, 32'h1234_5678, OK, "OP2 after stall");
      applyRead(7'h1C, 32'h9, OK, "OP3 after stall");

      // Interrupt enable and clear
      applyStimulus_writeOps(32'd10, 32'd20, 32'd30, 32'd40);
      applyWrite(7'h00, 32'h9, 4'hF, OK, "wr START+IRQ_EN");
      applyRead(7'h04, 32'h1, OK, "status busy irq");
      applyRead(7'h04, 32'h2, OK, "status done irq");
      checkOutput("irq with done", 32'(irq), 32'(IRQ_BUILD));
      applyRead(7'h08, 32'd100, OK, "result 10+20+30+40");
      applyRead(7'h00, {28'h0, IRQ_BUILD, 3'b000}, OK, "ctrl irq_en");
      applyWrite(7'h00, 32'hC, 4'hF, OK, "wr CLR_DONE irq");
      checkOutput("irq after clr_done", 32'(irq), 32'd0);
      applyRead(7'h04, 32'h0, OK, "status after irq clear");

      // Reset in the middle of a run aborts it
      applyWrite(7'h00, 32'h1, 4'hF, OK, "wr START abort");
      ARESETN = 1'b0;
      repeat (2) @(posedge ACLK);
      #1;
      ARESETN = 1'b1;
      @(posedge ACLK);
      #1;
      checkOutput("irq after mid-run reset", 32'(irq), 32'd0);
      applyRead(7'h04, 32'h0, OK, "status after mid-run reset");
      applyRead(7'h08, 32'h0, OK, "result after mid-run reset");
      applyRead(7'h10, 32'h0, OK, "OP0 after mid-run reset");

      repeat (3) @(posedge ACLK);
      checkOutput("B queue drained", 32'(bRespQ.size()), 32'd0);
      checkOutput("R queue drained", 32'(rDataQ.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
